obi_rr_arbiter: RTL
===================

Name: obi_rr_arbiter

Overview:
- Shares the single OBI slave port of the OBI-to-Wishbone bridge between NUM_M OBI masters (e.g. core instruction fetch, core data, debug module).
- Round-robin arbitration; at most one transaction in flight, matching the bridge's single-outstanding behaviour.
- Routes grant and response back to the owning master.
- A response timeout returns an error to the master if the bridge never answers.

Parameters:
- NUM_M, 2, number of OBI masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 1024, obi_clk_i cycles allowed in RESP before an error response; 0 disables the timeout.

Ports:
- obi_clk_i  in  1  OBI-domain clock; the only clock.
- soc_rst_i  in  1  synchronous, active-high reset.
- m_req_i  in  NUM_M  per-master request.
- m_gnt_o  out  NUM_M  per-master grant.
- m_addr_i  in  NUM_M*ADDR_W  flattened addresses; master k at [k*ADDR_W +: ADDR_W].
- m_wr_en_i  in  NUM_M  per-master write enable.
- m_byte_en_i  in  NUM_M*DATA_W/8  flattened byte enables.
- m_wdata_i  in  NUM_M*DATA_W  flattened write data.
- m_rvalid_o  out  NUM_M  per-master response valid.
- m_err_o  out  NUM_M  error qualifier, valid with m_rvalid_o.
- m_rdata_o  out  DATA_W  read data, broadcast to all masters.
- s_req_o  out  1  request to bridge.
- s_gnt_i  in  1  bridge grant.
- s_addr_o  out  ADDR_W  address to bridge.
- s_wr_en_o  out  1  write enable to bridge.
- s_byte_en_o  out  DATA_W/8  byte enables to bridge.
- s_wdata_o  out  DATA_W  write data to bridge.
- s_rvalid_i  in  1  bridge response valid.
- s_rdata_i  in  DATA_W  bridge read data.

Behaviour:
- Reset (soc_rst_i high at a clock edge):
  - state=IDLE; sel=0; last=NUM_M-1, so master 0 wins first.
  - Timeout counter 0; holding registers 0.
  - All outputs 0: s_req_o, s_*, m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o.
  - Reset mid-transaction discards it; no response is delivered.
- States: IDLE, ADDR, RESP, DRAIN.
- IDLE:
  - If any m_req_i is set, pick the first requester searching from (last+1) mod NUM_M upward with wrap.
  - Register sel and that master's addr/wr_en/byte_en/wdata into holding registers; go to ADDR.
  - Arbitration costs exactly one cycle; no grant is issued in IDLE.
- ADDR:
  - s_req_o=1; s_* are driven from the holding registers and are stable for the whole phase.
  - m_gnt_o[sel] = s_gnt_i (combinational, one-hot, single cycle).
  - On s_gnt_i: last<=sel, counter<=0, go to RESP.
  - If s_rvalid_i arrives in the same cycle as s_gnt_i, forward it as in RESP and go directly to IDLE.
- RESP:
  - s_req_o=0.
  - m_rvalid_o[sel]=s_rvalid_i, m_err_o=0, m_rdata_o=s_rdata_i (combinational pass-through).
  - On s_rvalid_i: go to IDLE.
  - Otherwise the counter increments each cycle. When counter==TIMEOUT_CYC-1 (TIMEOUT_CYC>0): drive m_rvalid_o[sel]=1, m_err_o[sel]=1, m_rdata_o=0 for one cycle, then go to DRAIN.
- DRAIN:
  - No outputs asserted.
  - The next s_rvalid_i is discarded, then go to IDLE.
  - DRAIN has no timeout.
- Outside the owning cycle, m_rdata_o=0, all m_gnt_o=0 and all m_rvalid_o=0.
- m_gnt_o and m_rvalid_o are never asserted to any master other than sel.
- Requests from other masters are ignored while not IDLE; they must hold m_req_i until granted (OBI rule).
- A master dropping m_req_i after selection does not abort the transaction; it completes and its response is still returned.
- Fairness: with all NUM_M masters requesting continuously, each master is granted once per NUM_M transactions.
- Throughput: one transaction per (1 + grant wait + response wait) cycles; back-to-back transactions have one IDLE cycle between them.

Test Plan:
1. Reset, then m_req_i=2'b01 with addr 0x0000_2000 (read); bridge gnt after 2 cycles, rvalid with 0xCAFE_0001 after 3 more -> exactly one m_gnt_o[0] pulse, s_addr_o=0x0000_2000, m_rvalid_o[0] with m_rdata_o=0xCAFE_0001, m_err_o=0.
2. NUM_M=3, all masters requesting continuously for 6 transactions -> grant order 0,1,2,0,1,2; m_gnt_o always one-hot.
3. Master 1 write: addr 0x10, wdata 0x1234_5678, byte_en 4'b0011, master changes m_wdata_i after selection -> s_wdata_o stays 0x1234_5678 and s_byte_en_o stays 4'b0011 until s_gnt_i.
4. TIMEOUT_CYC=8, bridge grants but never sends rvalid -> m_rvalid_o[sel]=1 and m_err_o[sel]=1 on the 8th RESP cycle; a later s_rvalid_i is discarded; next request is served normally.
5. soc_rst_i pulsed while in RESP -> all outputs 0 next cycle; a late s_rvalid_i produces no m_rvalid_o; the first post-reset grant goes to master 0.
6. Bridge asserts s_gnt_i and s_rvalid_i in the same cycle -> m_gnt_o[sel] and m_rvalid_o[sel] in the same cycle; state returns to IDLE.

Source files
------------

// File: rtl/obi_rr_arbiter_if.sv
// Bundle of every bus signal around obi_rr_arbiter. Signal suffixes (_i/_o)
// are from the arbiter's point of view.
//   slave  : the arbiter (OBI slave towards the masters, requester towards the bridge)
//   master : the environment (NUM_M OBI masters plus the OBI-to-Wishbone bridge)
// Master-side vectors are flattened; master k owns slice [k*W +: W].
interface obi_rr_arbiter_if #(
    parameter int unsigned NUM_M  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    // master side
    logic [NUM_M-1:0]        m_req_i;
    logic [NUM_M-1:0]        m_gnt_o;
    logic [NUM_M*ADDR_W-1:0] m_addr_i;
    logic [NUM_M-1:0]        m_wr_en_i;
    logic [NUM_M*BE_W-1:0]   m_byte_en_i;
    logic [NUM_M*DATA_W-1:0] m_wdata_i;
    logic [NUM_M-1:0]        m_rvalid_o;
    logic [NUM_M-1:0]        m_err_o;
    logic [DATA_W-1:0]       m_rdata_o;

    // bridge side
    logic                    s_req_o;
    logic                    s_gnt_i;
    logic [ADDR_W-1:0]       s_addr_o;
    logic                    s_wr_en_o;
    logic [BE_W-1:0]         s_byte_en_o;
    logic [DATA_W-1:0]       s_wdata_o;
    logic                    s_rvalid_i;
    logic [DATA_W-1:0]       s_rdata_i;

    modport slave (
        input  m_req_i, m_addr_i, m_wr_en_i, m_byte_en_i, m_wdata_i,
        input  s_gnt_i, s_rvalid_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o,
        output s_req_o, s_addr_o, s_wr_en_o, s_byte_en_o, s_wdata_o
    );

    modport master (
        output m_req_i, m_addr_i, m_wr_en_i, m_byte_en_i, m_wdata_i,
        output s_gnt_i, s_rvalid_i, s_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o,
        input  s_req_o, s_addr_o, s_wr_en_o, s_byte_en_o, s_wdata_o
    );
endinterface

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing the bridge's single OBI slave port between
// NUM_M OBI masters, with one transaction in flight and a response timeout.
// Ports:
//   obi_clk_i : the only clock
//   soc_rst_i : synchronous active-high reset
//   bus       : obi_rr_arbiter_if.slave (m_* per-master lanes, s_* bridge port)
// Grant and response are combinational pass-throughs of the bridge handshake,
// steered to the selected master; request payload comes from holding registers.
module obi_rr_arbiter #(
    parameter int unsigned NUM_M       = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic            obi_clk_i,
    input  logic            soc_rst_i,
    obi_rr_arbiter_if.slave bus
);
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RESP,
        ST_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;

    logic [NUM_M-1:0]  gnt_c;
    logic [NUM_M-1:0]  rvalid_c;
    logic [NUM_M-1:0]  err_c;
    logic [DATA_W-1:0] rdata_c;

    // First requester searching upward from the master after the last winner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_M; i++) begin
            cand = IDX_W'((32'(last_q) + i) % NUM_M);
            if (!pick_valid && bus.m_req_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and response steering.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wr_en_d  = wr_en_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        gnt_c    = '0;
        rvalid_c = '0;
        err_c    = '0;
        rdata_c  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    addr_d  = bus.m_addr_i[pick_idx*ADDR_W +: ADDR_W];
                    wr_en_d = bus.m_wr_en_i[pick_idx];
                    be_d    = bus.m_byte_en_i[pick_idx*BE_W +: BE_W];
                    wdata_d = bus.m_wdata_i[pick_idx*DATA_W +: DATA_W];
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                gnt_c[sel_q] = bus.s_gnt_i;
                if (bus.s_gnt_i) begin
                    last_d = sel_q;
                    cnt_d  = '0;
                    // Bridge may answer in the grant cycle itself.
                    if (bus.s_rvalid_i) begin
                        rvalid_c[sel_q] = 1'b1;
                        rdata_c         = bus.s_rdata_i;
                        state_d         = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bus.s_rvalid_i) begin
                    rvalid_c[sel_q] = 1'b1;
                    rdata_c         = bus.s_rdata_i;
                    state_d         = ST_IDLE;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                    rvalid_c[sel_q] = 1'b1;
                    err_c[sel_q]    = 1'b1;
                    state_d         = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                // Swallow the bridge's late answer to the timed-out request.
                if (bus.s_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge obi_clk_i) begin
        if (soc_rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= IDX_W'(NUM_M - 1);
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_en_q <= wr_en_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.m_gnt_o     = gnt_c;
    assign bus.m_rvalid_o  = rvalid_c;
    assign bus.m_err_o     = err_c;
    assign bus.m_rdata_o   = rdata_c;
    assign bus.s_req_o     = (state_q == ST_ADDR);
    assign bus.s_addr_o    = (state_q == ST_ADDR) ? addr_q  : '0;
    assign bus.s_wr_en_o   = (state_q == ST_ADDR) ? wr_en_q : 1'b0;
    assign bus.s_byte_en_o = (state_q == ST_ADDR) ? be_q    : '0;
    assign bus.s_wdata_o   = (state_q == ST_ADDR) ? wdata_q : '0;

endmodule
